// File: rtl/preamble_generator.sv
// 802.11a legacy preamble source: NUM_STS short symbols, 32-sample GI and two long symbols
// streamed as packed {I, Q} AXI-Stream beats with an optional arithmetic gain shift.
module preamble_generator #(
    parameter int unsigned NUM_STS    = 10,
    parameter int unsigned GAIN_SHIFT = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        pre_axis_tvalid,
    output logic [31:0] pre_axis_tdata,
    output logic        pre_axis_tlast,
    input  logic        pre_axis_tready
);

    typedef enum logic [2:0] {StIdle, StSts, StGi, StLts1, StLts2} state_e;

    localparam logic [8:0] StsLast = 9'(16 * NUM_STS - 1);

    state_e        state_q, state_d;
    logic [8:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic [31:0]   data_q, data_d;
    logic          hs;
    logic          load;
    logic [5:0]    lts_idx;
    logic [31:0]   rom_word;
    logic signed [15:0] rom_i, rom_q;

    function automatic logic [31:0] iq(input int i, input int q);
        return {16'(i), 16'(q)};
    endfunction

    function automatic logic [31:0] sts_rom(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:  v = iq(1507, 1507);    4'd1:  v = iq(-4325, 66);
            4'd2:  v = iq(-426, -2589);   4'd3:  v = iq(4686, -426);
            4'd4:  v = iq(3015, 0);       4'd5:  v = iq(4686, -426);
            4'd6:  v = iq(-426, -2589);   4'd7:  v = iq(-4325, 66);
            4'd8:  v = iq(1507, 1507);    4'd9:  v = iq(66, -4325);
            4'd10: v = iq(-2589, -426);   4'd11: v = iq(-426, 4686);
            4'd12: v = iq(0, 3015);       4'd13: v = iq(-426, 4686);
            4'd14: v = iq(-2589, -426);   default: v = iq(66, -4325);
        endcase
        return v;
    endfunction

    function automatic logic [31:0] lts_rom(input logic [5:0] idx);
        logic [31:0] v;
        case (idx)
            6'd0:  v = iq(5112, 0);       6'd1:  v = iq(-164, -3932);
            6'd2:  v = iq(1311, -3637);   6'd3:  v = iq(3178, 2720);
            6'd4:  v = iq(688, 918);      6'd5:  v = iq(1966, -2884);
            6'd6:  v = iq(-3768, -1802);  6'd7:  v = iq(-1245, -3473);
            6'd8:  v = iq(3211, -852);    6'd9:  v = iq(1737, 131);
            6'd10: v = iq(33, -3768);     6'd11: v = iq(-4489, -1540);
            6'd12: v = iq(786, -1933);    6'd13: v = iq(1933, -492);
            6'd14: v = iq(-721, 5276);    6'd15: v = iq(3899, -164);
            6'd16: v = iq(2032, 2032);    6'd17: v = iq(1212, -3211);
            6'd18: v = iq(-1868, -1278);  6'd19: v = iq(-4293, -2130);
            6'd20: v = iq(2687, -3015);   6'd21: v = iq(2294, -459);
            6'd22: v = iq(-1966, -2654);  6'd23: v = iq(-1835, 721);
            6'd24: v = iq(-1147, 4948);   6'd25: v = iq(-3998, 557);
            6'd26: v = iq(-4162, 688);    6'd27: v = iq(2458, 2425);
            6'd28: v = iq(-98, -1769);    6'd29: v = iq(-3015, 3768);
            6'd30: v = iq(3015, 3473);    6'd31: v = iq(393, 3211);
            6'd32: v = iq(-5112, 0);      6'd33: v = iq(393, -3211);
            6'd34: v = iq(3015, -3473);   6'd35: v = iq(-3015, -3768);
            6'd36: v = iq(-98, 1769);     6'd37: v = iq(2458, -2425);
            6'd38: v = iq(-4162, -688);   6'd39: v = iq(-3998, -557);
            6'd40: v = iq(-1147, -4948);  6'd41: v = iq(-1835, -721);
            6'd42: v = iq(-1966, 2654);   6'd43: v = iq(2294, 459);
            6'd44: v = iq(2687, 3015);    6'd45: v = iq(-4293, 2130);
            6'd46: v = iq(-1868, 1278);   6'd47: v = iq(1212, 3211);
            6'd48: v = iq(2032, -2032);   6'd49: v = iq(3899, 164);
            6'd50: v = iq(-721, -5276);   6'd51: v = iq(1933, 492);
            6'd52: v = iq(786, 1933);     6'd53: v = iq(-4489, 1540);
            6'd54: v = iq(33, 3768);      6'd55: v = iq(1737, -131);
            6'd56: v = iq(3211, 852);     6'd57: v = iq(-1245, 3473);
            6'd58: v = iq(-3768, 1802);   6'd59: v = iq(1966, 2884);
            6'd60: v = iq(688, -918);     6'd61: v = iq(3178, -2720);
            6'd62: v = iq(1311, 3637);    default: v = iq(-164, 3932);
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        data_d  = data_q;
        load    = 1'b0;
        hs      = valid_q && pre_axis_tready;

        unique case (state_q)
            StIdle: if (start_in) begin
                state_d = StSts;
                cnt_d   = '0;
                valid_d = 1'b1;
                load    = 1'b1;
            end
            StSts: if (hs) begin
                load = 1'b1;
                if (cnt_q == StsLast) begin
                    state_d = StGi;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 9'd1;
            end
            StGi: if (hs) begin
                load = 1'b1;
                if (cnt_q == 9'd31) begin
                    state_d = StLts1;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 9'd1;
            end
            StLts1: if (hs) begin
                load = 1'b1;
                if (cnt_q == 9'd63) begin
                    state_d = StLts2;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 9'd1;
            end
            StLts2: if (hs) begin
                if (cnt_q == 9'd63) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    data_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    load   = 1'b1;
                    cnt_d  = cnt_q + 9'd1;
                    last_d = (cnt_q == 9'd62);
                end
            end
            default: state_d = StIdle;
        endcase

        // ROM address follows the next position so tdata is registered with its index
        lts_idx  = (state_d == StGi) ? {1'b1, cnt_d[4:0]} : cnt_d[5:0];
        rom_word = (state_d == StSts) ? sts_rom(cnt_d[3:0]) : lts_rom(lts_idx);
        rom_i    = rom_word[31:16];
        rom_q    = rom_word[15:0];
        if (load) data_d = {16'(rom_i >>> GAIN_SHIFT), 16'(rom_q >>> GAIN_SHIFT)};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign pre_axis_tvalid = valid_q;
    assign pre_axis_tdata  = data_q;
    assign pre_axis_tlast  = last_q;
    assign busy_out        = valid_q;
    assign done_out        = done_q;

endmodule

// File: tb/tb_preamble_generator.sv
// Bench for preamble_generator: default instance and a NUM_STS=2 / GAIN_SHIFT=4 instance,
// checked against a model built from the real-valued 802.11a training tables.
module tb_preamble_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b, tready, sel;
    logic busy_a, done_a, valid_a, last_a, busy_b, done_b, valid_b, last_b;
    logic [31:0] data_a, data_b;

    preamble_generator dut_a (
        .clk_in(clk), .rst_in(rst), .start_in(start_a), .busy_out(busy_a), .done_out(done_a),
        .pre_axis_tvalid(valid_a), .pre_axis_tdata(data_a), .pre_axis_tlast(last_a),
        .pre_axis_tready(tready)
    );

    preamble_generator #(.NUM_STS(2), .GAIN_SHIFT(4)) dut_b (
        .clk_in(clk), .rst_in(rst), .start_in(start_b), .busy_out(busy_b), .done_out(done_b),
        .pre_axis_tvalid(valid_b), .pre_axis_tdata(data_b), .pre_axis_tlast(last_b),
        .pre_axis_tready(tready)
    );

    logic        mon_valid, mon_last, mon_busy, mon_done;
    logic [31:0] mon_data;
    assign mon_valid = sel ? valid_b : valid_a;
    assign mon_last  = sel ? last_b  : last_a;
    assign mon_busy  = sel ? busy_b  : busy_a;
    assign mon_done  = sel ? done_b  : done_a;
    assign mon_data  = sel ? data_b  : data_a;

    int checks = 0;
    int errors = 0;
    real sts_re[16], sts_im[16], lts_re[33], lts_im[33];
    logic [31:0] cap[$];
    logic        capl[$];
    logic [31:0] ref0[$];

    typedef struct {
        bit    inst_b;
        int    beat;
        int    i;
        int    q;
        string nm;
    } spot_t;
    spot_t spots[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int quant(input real x, input int g);
        real v;
        int  r;
        v = x * 32768.0;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return $rtoi($floor(real'(r) / (2.0 ** g)));
    endfunction

    // Sample n of the preamble; LTS[33..63] from conjugate symmetry of the real-valued spectrum
    function automatic logic [31:0] model_word(input int num_sts, input int g, input int n);
        int  s, k;
        real re, im;
        s = 16 * num_sts;
        if (n < s) begin
            re = sts_re[n % 16];
            im = sts_im[n % 16];
        end else begin
            if (n < s + 32) k = 32 + n - s;
            else if (n < s + 96) k = n - s - 32;
            else k = n - s - 96;
            if (k <= 32) begin
                re = lts_re[k];
                im = lts_im[k];
            end else begin
                re = lts_re[64 - k];
                im = -lts_im[64 - k];
            end
        end
        return {16'(quant(re, g)), 16'(quant(im, g))};
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else start_a = v;
    endtask

    // Start one preamble, capture accepted beats, then check the done/idle tail
    task automatic run_stream(input int n_exp, input bit rnd, input bit start_on_last);
        int          cycles = 0;
        int          stab_err = 0;
        int          busy_err = 0;
        bit          finished = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic        rdy;
        cap.delete();
        capl.delete();
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        while (!finished && cycles < 5000) begin
            if (prev_stall && (mon_data !== prev_data || mon_last !== prev_last)) stab_err++;
            if (mon_busy !== 1'b1 || mon_valid !== 1'b1) busy_err++;
            rdy    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tready = rdy;
            if (rdy) begin
                cap.push_back(mon_data);
                capl.push_back(mon_last);
                if (cap.size() == n_exp) finished = 1;
            end
            if (finished && start_on_last) set_start(1'b1);
            prev_stall = !rdy;
            prev_data  = mon_data;
            prev_last  = mon_last;
            cycles++;
            @(negedge clk);
            set_start(1'b0);
        end
        tready = 1'b1;
        check("stream_complete", 32'(finished), 32'd1);
        check("stall_stability", 32'(stab_err), 32'd0);
        check("valid_busy_held", 32'(busy_err), 32'd0);
        check("tail_v_l_b_d", {28'd0, mon_valid, mon_last, mon_busy, mon_done}, 32'b0001);
        @(negedge clk);
        check("done_one_cycle", 32'(mon_done), 32'd0);
    endtask

    task automatic compare_stream(input int num_sts, input int g);
        int n;
        n = 16 * num_sts + 160;
        check("beat_count", 32'(cap.size()), 32'(n));
        for (int k = 0; k < n && k < cap.size(); k++) begin
            check($sformatf("beat%0d_data", k), cap[k], model_word(num_sts, g, k));
            check($sformatf("beat%0d_last", k), 32'(capl[k]), 32'(k == n - 1));
        end
    endtask

    task automatic apply_spots(input bit inst_b);
        foreach (spots[j]) begin
            if (spots[j].inst_b == inst_b && spots[j].beat < cap.size())
                check(spots[j].nm, cap[spots[j].beat], {16'(spots[j].i), 16'(spots[j].q)});
        end
    endtask

    initial begin
        int bad;
        int idx;
        sts_re = '{0.046, -0.132, -0.013, 0.143, 0.092, 0.143, -0.013, -0.132,
                   0.046, 0.002, -0.079, -0.013, 0.0, -0.013, -0.079, 0.002};
        sts_im = '{0.046, 0.002, -0.079, -0.013, 0.0, -0.013, -0.079, 0.002,
                   0.046, -0.132, -0.013, 0.143, 0.092, 0.143, -0.013, -0.132};
        lts_re = '{0.156, -0.005, 0.040, 0.097, 0.021, 0.060, -0.115, -0.038, 0.098, 0.053,
                   0.001, -0.137, 0.024, 0.059, -0.022, 0.119, 0.062, 0.037, -0.057, -0.131,
                   0.082, 0.070, -0.060, -0.056, -0.035, -0.122, -0.127, 0.075, -0.003,
                   -0.092, 0.092, 0.012, -0.156};
        lts_im = '{0.0, -0.120, -0.111, 0.083, 0.028, -0.088, -0.055, -0.106, -0.026, 0.004,
                   -0.115, -0.047, -0.059, -0.015, 0.161, -0.005, 0.062, -0.098, -0.039,
                   -0.065, -0.092, -0.014, -0.081, 0.022, 0.151, 0.017, 0.021, 0.074, -0.054,
                   0.115, 0.106, 0.098, 0.0};
        spots = '{
            '{0, 0,   1507,  1507, "a_beat0"},
            '{0, 1,   -4325, 66,   "a_beat1"},
            '{0, 16,  1507,  1507, "a_beat16"},
            '{0, 160, -5112, 0,    "a_gi_first"},
            '{0, 161, 393,   -3211, "a_gi_second"},
            '{0, 192, 5112,  0,    "a_lts1_first"},
            '{0, 224, -5112, 0,    "a_lts1_mid"},
            '{0, 256, 5112,  0,    "a_lts2_first"},
            '{0, 319, -164,  3932, "a_last"},
            '{1, 0,   94,    94,   "b_beat0"},
            '{1, 1,   -271,  4,    "b_floor_neg"},
            '{1, 32,  -320,  0,    "b_gi_floor"},
            '{1, 64,  319,   0,    "b_lts1_first"},
            '{1, 191, -11,   245,  "b_last"}
        };

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; tready = 1'b0; sel = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {28'd0, valid_a, last_a, busy_a, done_a}, 32'd0);
        check("reset_data", data_a, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_valid", 32'(valid_a), 32'd0);

        // Default parameters, continuous ready
        run_stream(320, 0, 0);
        compare_stream(10, 0);
        apply_spots(0);
        bad = 0;
        for (int k = 0; k < 64; k++) if (cap[192 + k] !== cap[256 + k]) bad++;
        check("lts1_equals_lts2", 32'(bad), 32'd0);
        ref0 = cap;

        // Random backpressure
        run_stream(320, 1, 0);
        compare_stream(10, 0);
        bad = 0;
        foreach (ref0[k]) if (k >= cap.size() || cap[k] !== ref0[k]) bad++;
        check("random_ready_same", 32'(bad), 32'd0);

        // Shifted, short instance
        sel = 1'b1;
        run_stream(192, 1, 0);
        compare_stream(2, 4);
        apply_spots(1);
        sel = 1'b0;

        // start held high: back-to-back preambles with a single idle cycle
        tready = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int c = 0; c <= 642; c++) begin
            if (c == 640) start_a = 1'b0;
            if (c == 320 || c >= 641) begin
                if (valid_a !== 1'b0) bad++;
                if (done_a !== ((c == 320 || c == 641) ? 1'b1 : 1'b0)) bad++;
            end else begin
                idx = (c < 320) ? c : c - 321;
                if (valid_a !== 1'b1 || data_a !== model_word(10, 0, idx)) bad++;
                if (last_a !== (idx == 319)) bad++;
            end
            @(negedge clk);
        end
        check("hold_start_pattern", 32'(bad), 32'd0);

        // Asynchronous reset mid-stream at beat 100
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        check("beat100_before_reset", data_a, model_word(10, 0, 100));
        #2 rst = 1'b1;
        #1;
        check("async_reset_ctrl", {28'd0, valid_a, last_a, busy_a, done_a}, 32'd0);
        check("async_reset_data", data_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_stream(320, 0, 0);
        compare_stream(10, 0);

        // Start coincident with the final handshake is dropped
        run_stream(320, 0, 1);
        bad = 0;
        repeat (20) begin
            if (valid_a !== 1'b0 || busy_a !== 1'b0) bad++;
            @(negedge clk);
        end
        check("start_at_final_ignored", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/preamble_generator.md
# preamble_generator

Transmit-side counterpart of the LTS extraction path. On a start request it emits one 802.11a legacy training preamble as an AXI-Stream of packed I/Q samples: NUM_STS short training symbols, then the 32-sample guard interval, then two 64-sample long training symbols. It sits ahead of the DAC/loopback path and is the stimulus source for on-target validation of the receive chain.

## Interface
- NUM_STS, default 10: number of 16-sample short training symbols (legal 1..15).
- GAIN_SHIFT, default 0: arithmetic right shift applied to I and Q before output (legal 0..15).
- Reset is asynchronous and active-high.
- clk_in  input  1  single clock for all logic.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  request one preamble; sampled only in IDLE.
- busy_out  output  1  high from the cycle after start is accepted until the final beat's handshake.
- done_out  output  1  one-cycle pulse on the cycle after the final beat's handshake.
- pre_axis_tvalid  output  1  sample valid.
- pre_axis_tdata  output  32  {I[15:0], Q[15:0]}, two's complement.
- pre_axis_tlast  output  1  high on the final sample only.
- pre_axis_tready  input  1  downstream ready.

## Operation
- ROMs: STS table of 16 complex samples and LTS table of 64 complex samples. Values are the 802.11a time-domain training values ×32768, rounded to nearest, saturated to [-32768, 32767]. Reference values: STS[0] = {1507, 1507}; LTS[0] = {5112, 0}.
- Output index n runs over N = 16·NUM_STS + 160 samples. With S = 16·NUM_STS:
  - n < S: STS[n mod 16].
  - S ≤ n < S+32: LTS[32 + (n−S)] (guard interval).
  - S+32 ≤ n < S+96: LTS[n−S−32].
  - S+96 ≤ n < S+160: LTS[n−S−96].
- Default N is 320.
- Gain: each component is output as ROM value >>> GAIN_SHIFT (arithmetic shift, sign preserved, truncation toward −inf).
- States:
  - IDLE: start_in=1 → STS, with n=0.
  - STS: after the handshake at n=S−1 → GI.
  - GI: after the handshake at n=S+31 → LTS1.
  - LTS1: after the handshake at n=S+95 → LTS2.
  - LTS2: after the handshake at n=S+159 → IDLE, and done_out pulses.
- n advances only on a handshake (tvalid && tready).
- start_in outside IDLE is ignored. Requests are not queued, including a start_in in the same cycle as the final handshake.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, busy_out=0, done_out=0, state=IDLE, n=0. Outputs clear immediately on rst_in (asynchronous). Reset mid-preamble abandons the stream with no tlast.
- All outputs are registered.
- Start latency: start_in high at edge k (IDLE) → at edge k the outputs become tvalid=1, tdata=sample 0, busy_out=1. They are visible in cycle k+1.
- AXI rules:
  - Once tvalid rises it stays high until the final handshake.
  - tdata and tlast hold stable while tready=0.
  - On a handshake the next sample is presented at the same edge: zero bubbles, one sample per clock at tready=1.
- Throughput: with tready held high, N consecutive valid cycles (320 at default); busy_out is high for exactly N cycles.
- tlast is high only with sample n=N−1.
- After the final handshake, in the next cycle: tvalid=0, tlast=0, busy_out=0, done_out=1. done_out is low in the following cycle.
- Back-to-back: a start_in in the cycle where done_out=1 is accepted (state is IDLE). The minimum gap between preambles is therefore 1 idle cycle.
- tready is ignored while tvalid=0.

## Test plan
- Default parameters, tready=1, single start pulse:
  - 320 beats, contiguous.
  - Beat 0 = {1507, 1507}; beat 16 = beat 0; beat 192 = {5112, 0}; beat 160 = beat 224 (GI = LTS[32]); beats 192..255 equal beats 256..319.
  - tlast only on beat 319; done_out pulses once.
- Random tready (50%) with default parameters:
  - Captured stream identical to the tready=1 capture.
  - tdata and tlast never change while tvalid && !tready.
  - busy_out stays high until beat 319 is accepted.
- GAIN_SHIFT=4, NUM_STS=2:
  - 192 beats; beat 0 = {94, 94}; beat 64 = {319, 0}.
  - Negative samples are floor-shifted.
  - tlast on beat 191.
- start_in held high continuously:
  - Preambles repeat with exactly 1 idle cycle between them.
  - Extra start pulses during busy_out do not lengthen or restart the stream.
- rst_in asserted asynchronously at beat 100:
  - All outputs go to 0 before the next clock edge.
  - After release, a new start produces beat 0 = {1507, 1507}.
- Start asserted in the same cycle as the final handshake:
  - The request is ignored; no second preamble follows.
